// File: rtl/bcd_step_counter.sv
// Push-button driven packed-BCD counter with synchronised, debounced increment and load buttons.
// Optional feature macro: BCD_AUTO_REPEAT_EN (auto-repeat on a held increment button).

module bcd_step_counter_btn #(
  parameter int DB_CYCLES = 4
`ifdef BCD_AUTO_REPEAT_EN
  ,
  parameter bit REPEAT_EN     = 1'b0,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 5
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic accept_o
);

  localparam int TW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} btnState_e;

  btnState_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    sync_q;
  logic          synced;
  logic          pressAccept;
  logic          repFire;

  assign synced = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pressAccept = 1'b0;
    case (state_q)
      IDLE: begin
        if (synced) begin
          state_d = DB_PRESS;
          timer_d = '0;
        end
      end
      DB_PRESS: begin
        if (!synced) begin
          state_d = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          state_d     = HELD;
          pressAccept = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HELD: begin
        if (!synced) begin
          state_d = DB_REL;
          timer_d = '0;
        end
      end
      DB_REL: begin
        if (synced) begin
          state_d = HELD;
        end else if (timer_q == TIMER_LAST) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

`ifdef BCD_AUTO_REPEAT_EN
  if (REPEAT_EN) begin : g_rep
    localparam int RW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    logic [RW-1:0] rep_q, rep_d;
    logic          fire;

    // After the first repeat the counter restarts part-way so later repeats come every REPEAT_PERIOD.
    always_comb begin
      rep_d = '0;
      fire  = 1'b0;
      if (state_q == HELD && synced) begin
        if (rep_q == RW'(REPEAT_DELAY - 1)) begin
          fire  = 1'b1;
          rep_d = RW'(REPEAT_DELAY - REPEAT_PERIOD);
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_q <= '0;
      end else begin
        rep_q <= rep_d;
      end
    end

    assign repFire = fire;
  end else begin : g_noRep
    assign repFire = 1'b0;
  end
`else
  assign repFire = 1'b0;
`endif

  assign accept_o = pressAccept | repFire;

endmodule

module bcd_step_counter #(
  parameter int DIGITS        = 3,
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                btn_inc,
  input  logic                btn_load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                inc_pulse,
  output logic                wrap
);

  if (DB_CYCLES < 1 || REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_badCfg
    $error("bcd_step_counter: illegal DB_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
  end

  logic [1:0]          rstSync_q;
  logic                rstSyncN;
  logic                incAccept;
  logic                loadAccept;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                incPulse_q, incPulse_d;
  logic                wrap_q, wrap_d;
  logic [4*DIGITS-1:0] bcdInc;
  logic [4*DIGITS-1:0] loadSat;
  logic                carry;
  logic                allNines;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstSyncN = rstSync_q[1];

  bcd_step_counter_btn #(
    .DB_CYCLES    (DB_CYCLES)
`ifdef BCD_AUTO_REPEAT_EN
    ,
    .REPEAT_EN    (1'b1),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_incBtn (
    .clk     (clk),
    .rst_n   (rstSyncN),
    .btn_i   (btn_inc),
    .accept_o(incAccept)
  );

  bcd_step_counter_btn #(
    .DB_CYCLES    (DB_CYCLES)
`ifdef BCD_AUTO_REPEAT_EN
    ,
    .REPEAT_EN    (1'b0),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_loadBtn (
    .clk     (clk),
    .rst_n   (rstSyncN),
    .btn_i   (btn_load),
    .accept_o(loadAccept)
  );

  // Ripple-carry BCD increment; a carry out of the top digit means the count was all 9s.
  always_comb begin
    carry   = 1'b1;
    bcdInc  = '0;
    loadSat = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry && bcd_q[4*i +: 4] == 4'd9) begin
        bcdInc[4*i +: 4] = 4'd0;
      end else if (carry) begin
        bcdInc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
        carry            = 1'b0;
      end else begin
        bcdInc[4*i +: 4] = bcd_q[4*i +: 4];
      end
      loadSat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
    allNines = carry;
  end

  always_comb begin
    bcd_d      = bcd_q;
    incPulse_d = 1'b0;
    wrap_d     = 1'b0;
    if (loadAccept) begin
      bcd_d = loadSat;
    end else if (incAccept) begin
      bcd_d      = bcdInc;
      incPulse_d = 1'b1;
      wrap_d     = allNines;
    end
  end

  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN) begin
      bcd_q      <= '0;
      incPulse_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      bcd_q      <= bcd_d;
      incPulse_q <= incPulse_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign inc_pulse = incPulse_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Self-checking bench for bcd_step_counter: directed scenarios plus random presses, loads and glitches
// compared against a decimal-arithmetic model of the count.

module tb_bcd_step_counter;

  localparam int DIGITS        = 3;
  localparam int DB_CYCLES     = 4;
  localparam int REPEAT_DELAY  = 20;
  localparam int REPEAT_PERIOD = 5;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        btn_inc  = 1'b0;
  logic        btn_load = 1'b0;
  logic [11:0] load_val = '0;
  logic [11:0] bcd_out;
  logic        inc_pulse;
  logic        wrap;

  int nChecks = 0;
  int nFails  = 0;

  int expCount = 0;
  int expIncs  = 0;
  int expWraps = 0;

  int   incSeen   = 0;
  int   wrapSeen  = 0;
  int   pulseWide = 0;
  int   badDigit  = 0;
  int   wrapBad   = 0;
  logic incPrev   = 1'b0;

  bcd_step_counter #(
    .DIGITS       (DIGITS),
    .DB_CYCLES    (DB_CYCLES),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_inc  (btn_inc),
    .btn_load (btn_load),
    .load_val (load_val),
    .bcd_out  (bcd_out),
    .inc_pulse(inc_pulse),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // Strobe bookkeeping and output invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (inc_pulse) incSeen++;
      if (wrap) wrapSeen++;
      if (inc_pulse && incPrev) pulseWide++;
      if (wrap && (!inc_pulse || bcd_out != 12'h000)) wrapBad++;
      for (int i = 0; i < DIGITS; i++) begin
        if (bcd_out[4*i +: 4] > 4'd9) badDigit++;
      end
    end
    incPrev = inc_pulse;
  end

  function automatic int bcdToInt(input logic [11:0] v);
    int total;
    int d;
    total = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      total = total * 10 + d;
    end
    return total;
  endfunction

  function automatic logic [11:0] intToBcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic modelInc();
    expCount = (expCount + 1) % 1000;
    expIncs++;
    if (expCount == 0) expWraps++;
  endtask

  task automatic modelLoad(input logic [11:0] v);
    expCount = bcdToInt(v);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Drive one button action from a negedge, then leave time for the release debounce.
  task automatic applyStimulus(input bit pressInc, input bit pressLoad,
                               input logic [11:0] val, input int hold);
    load_val = val;
    btn_inc  = pressInc;
    btn_load = pressLoad;
    repeat (hold) @(negedge clk);
    btn_inc  = 1'b0;
    btn_load = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int incBase;
    int wrapBase;
    int kind;
    int hold;
    bit which;
    logic [11:0] v;

    $display("[TB] bcd_step_counter bench start");
    repeat (3) @(negedge clk);
    checkOutput("reset_bcd", 32'(bcd_out), 32'h000);
    checkOutput("reset_inc", 32'(inc_pulse), 32'h0);
    checkOutput("reset_wrap", 32'(wrap), 32'h0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Clean press: exact latency, single one-cycle strobe.
    incBase  = incSeen;
    btn_inc  = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("lat_before", 32'(bcd_out), 32'h000);
    @(negedge clk);
    checkOutput("lat_after", 32'(bcd_out), 32'h001);
    checkOutput("lat_pulse", 32'(inc_pulse), 32'h1);
    @(negedge clk);
    checkOutput("pulse_one_cycle", 32'(inc_pulse), 32'h0);
    repeat (2) @(negedge clk);
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    modelInc();
    checkOutput("clean_bcd", 32'(bcd_out), 32'(intToBcd(expCount)));
    checkOutput("clean_pulses", 32'(incSeen - incBase), 32'd1);

    // Bounce: two-cycle toggles never debounce.
    incBase = incSeen;
    for (int i = 0; i < 10; i++) begin
      btn_inc = ~btn_inc;
      repeat (2) @(negedge clk);
    end
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("bounce_bcd", 32'(bcd_out), 32'(intToBcd(expCount)));
    checkOutput("bounce_pulses", 32'(incSeen - incBase), 32'd0);

    // Load 999 then roll over.
    applyStimulus(1'b0, 1'b1, 12'h999, 8);
    modelLoad(12'h999);
    checkOutput("load999", 32'(bcd_out), 32'h999);
    incBase  = incSeen;
    wrapBase = wrapSeen;
    applyStimulus(1'b1, 1'b0, 12'h000, 8);
    modelInc();
    checkOutput("wrap_bcd", 32'(bcd_out), 32'(intToBcd(expCount)));
    checkOutput("wrap_count", 32'(wrapSeen - wrapBase), 32'd1);
    checkOutput("wrap_incs", 32'(incSeen - incBase), 32'd1);

    // Saturating load, then simultaneous load and increment.
    applyStimulus(1'b0, 1'b1, 12'h1A9, 8);
    modelLoad(12'h1A9);
    checkOutput("sat_load", 32'(bcd_out), 32'h199);
    incBase = incSeen;
    applyStimulus(1'b1, 1'b1, 12'h3F7, 8);
    modelLoad(12'h3F7);
    checkOutput("both_bcd", 32'(bcd_out), 32'h397);
    checkOutput("both_pulses", 32'(incSeen - incBase), 32'd0);

    // Reset while the increment button is held mid-debounce.
    applyStimulus(1'b0, 1'b1, 12'h042, 8);
    modelLoad(12'h042);
    checkOutput("pre_rst_load", 32'(bcd_out), 32'h042);
    btn_inc = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async_bcd", 32'(bcd_out), 32'h000);
    expCount = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rst_redebounce", 32'(bcd_out), 32'h000);
    repeat (11) @(negedge clk);
    modelInc();
    checkOutput("rst_one_inc", 32'(bcd_out), 32'(intToBcd(expCount)));
    btn_inc = 1'b0;
    repeat (12) @(negedge clk);

    // Long hold from zero.
    applyStimulus(1'b0, 1'b1, 12'h000, 8);
    modelLoad(12'h000);
    applyStimulus(1'b1, 1'b0, 12'h000, 40);
`ifdef BCD_AUTO_REPEAT_EN
    repeat (5) modelInc();
`else
    modelInc();
`endif
    checkOutput("long_hold", 32'(bcd_out), 32'(intToBcd(expCount)));

    // Random presses, loads, simultaneous presses and short glitches.
    for (int op = 0; op < 40; op++) begin
      kind = $urandom_range(0, 5);
      v    = 12'($urandom);
      case (kind)
        0, 1, 2: begin
          hold = $urandom_range(6, 12);
          applyStimulus(1'b1, 1'b0, v, hold);
          modelInc();
        end
        3: begin
          hold = $urandom_range(6, 12);
          applyStimulus(1'b0, 1'b1, v, hold);
          modelLoad(v);
        end
        4: begin
          hold = $urandom_range(6, 12);
          applyStimulus(1'b1, 1'b1, v, hold);
          modelLoad(v);
        end
        default: begin
          which = 1'($urandom_range(0, 1));
          hold  = $urandom_range(1, 3);
          applyStimulus(which, ~which, v, hold);
        end
      endcase
      checkOutput($sformatf("rand%0d", op), 32'(bcd_out), 32'(intToBcd(expCount)));
    end

    checkOutput("total_incs", 32'(incSeen), 32'(expIncs));
    checkOutput("total_wraps", 32'(wrapSeen), 32'(expWraps));
    checkOutput("pulse_width", 32'(pulseWide), 32'd0);
    checkOutput("wrap_coincide", 32'(wrapBad), 32'd0);
    checkOutput("digit_range", 32'(badDigit), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
